// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the RV32I load/store unit.
//   - funct3 encodings for access size and signedness
//   - FSM state type used by load_store_unit
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for the load/store unit.
//   Request side (the incoming access):
//     req_is_store, req_funct3, req_off, req_wdata -> req_wstrb, req_lane_wdata, req_err
//     req_err flags an undefined funct3 or a misaligned halfword/word.
//     Strobes and lane data are zero for loads and for erroneous requests.
//   Load side (the access in flight):
//     ld_funct3, ld_off, ld_rdata -> ld_data (sign- or zero-extended)
module lsu_align
    import lsu_pkg::*;
(
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [1:0]  req_off,
    input  logic [31:0] req_wdata,
    output logic [3:0]  req_wstrb,
    output logic [31:0] req_lane_wdata,
    output logic        req_err,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic signed [7:0]  byte_sel;
    logic signed [15:0] half_sel;

    always_comb begin
        req_wstrb      = '0;
        req_lane_wdata = '0;
        req_err        = 1'b0;
        case (req_funct3)
            F3_B: begin
                req_wstrb      = 4'b0001 << req_off;
                req_lane_wdata = {4{req_wdata[7:0]}};
            end
            F3_H: begin
                req_err        = req_off[0];
                req_wstrb      = 4'b0011 << req_off;
                req_lane_wdata = {2{req_wdata[15:0]}};
            end
            F3_W: begin
                req_err        = (req_off != 2'b00);
                req_wstrb      = 4'b1111;
                req_lane_wdata = req_wdata;
            end
            // Unsigned variants exist only for loads.
            F3_BU:   req_err = req_is_store;
            F3_HU:   req_err = req_is_store | req_off[0];
            default: req_err = 1'b1;
        endcase
        if (!req_is_store || req_err) begin
            req_wstrb      = '0;
            req_lane_wdata = '0;
        end
    end

    always_comb begin
        byte_sel = ld_rdata[{ld_off, 3'b000} +: 8];
        half_sel = ld_rdata[{ld_off[1], 4'b0000} +: 16];
        case (ld_funct3)
            F3_B:    ld_data = 32'(byte_sel);
            F3_H:    ld_data = 32'(half_sel);
            F3_BU:   ld_data = {24'd0, byte_sel};
            F3_HU:   ld_data = {16'd0, half_sel};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage of the RV32I core.
//   Request port : req_valid/req_ready handshake with req_is_store, req_funct3,
//                  req_addr (effective address) and req_wdata (rs2).
//   Memory port  : mem_valid/mem_ready handshake with word-aligned mem_addr,
//                  mem_we, mem_wstrb and lane-aligned mem_wdata; mem_rdata is
//                  sampled in the mem_ready cycle of a load.
//   Response port: resp_valid one-cycle pulse with registered resp_rdata
//                  (extended load data, 0 for stores/errors) and resp_err.
//   One access at a time: IDLE -> ACCESS -> RESP, or IDLE -> RESP on error.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [3:0]            mem_wstrb,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err
);

    lsu_state_t state, state_nxt;

    logic        accept;
    logic [3:0]  req_wstrb;
    logic [31:0] req_lane_wdata;
    logic        req_err;
    logic [31:0] ld_data;

    logic [ADDR_WIDTH-1:0] addr_p1;
    logic [1:0]            off_p1;
    logic [2:0]            funct3_p1;
    logic                  we_p1;
    logic [3:0]            wstrb_p1;
    logic [31:0]           wdata_p1;

    assign accept = (state == S_IDLE) && req_valid;

    lsu_align u_align (
        .req_is_store   (req_is_store),
        .req_funct3     (req_funct3),
        .req_off        (req_addr[1:0]),
        .req_wdata      (req_wdata),
        .req_wstrb      (req_wstrb),
        .req_lane_wdata (req_lane_wdata),
        .req_err        (req_err),
        .ld_funct3      (funct3_p1),
        .ld_off         (off_p1),
        .ld_rdata       (mem_rdata),
        .ld_data        (ld_data)
    );

    // Stage p1: request latched at acceptance, already lane-steered.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p1   <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            off_p1    <= req_addr[1:0];
            funct3_p1 <= req_funct3;
            we_p1     <= req_is_store;
            wstrb_p1  <= req_wstrb;
            wdata_p1  <= req_lane_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept && req_err) begin
                resp_rdata <= '0;
                resp_err   <= 1'b1;
            end else if ((state == S_ACCESS) && mem_ready) begin
                resp_rdata <= we_p1 ? 32'd0 : ld_data;
                resp_err   <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (req_valid) state_nxt = req_err ? S_RESP : S_ACCESS;
            S_ACCESS: if (mem_ready) state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Memory outputs are gated by state so an asynchronous reset clears them
    // immediately, even though the latched request itself is not reset.
    always_comb begin
        req_ready  = (state == S_IDLE);
        mem_valid  = (state == S_ACCESS);
        resp_valid = (state == S_RESP);
        mem_addr   = mem_valid ? addr_p1  : '0;
        mem_we     = mem_valid ? we_p1    : 1'b0;
        mem_wstrb  = mem_valid ? wstrb_p1 : 4'b0000;
        mem_wdata  = mem_valid ? wdata_p1 : 32'd0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wstrb    (mem_wstrb),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every response is compared against the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (resp_valid === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL resp_unexpected: got resp rdata=%h err=%b, required no response",
                         resp_rdata, resp_err);
            end else begin
                e = exp_q.pop_front();
                if ({resp_rdata, resp_err} !== {e.rdata, e.err}) begin
                    fails++;
                    $display("FAIL resp_payload: got rdata=%h err=%b, required rdata=%h err=%b",
                             resp_rdata, resp_err, e.rdata, e.err);
                end
            end
        end
    end

    // Presents one request in IDLE; returns 1ns after the accepting edge.
    task automatic drive_req(input logic st, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk); #1;
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = a;
        req_wdata    = wd;
        @(posedge clk); #1;
        req_valid    = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++;
        if ({req_ready, mem_valid, mem_we, mem_wstrb, mem_wdata, mem_addr,
             resp_valid, resp_rdata, resp_err} !== {1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
             1'b0, 32'h0, 1'b0}) begin
            fails++;
            $display("FAIL reset_values: got ready=%b mvalid=%b we=%b strb=%h wdata=%h addr=%h rvalid=%b rdata=%h err=%b, required ready=1 rest 0",
                     req_ready, mem_valid, mem_we, mem_wstrb, mem_wdata, mem_addr,
                     resp_valid, resp_rdata, resp_err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_store_cycle(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] wd, input logic [31:0] exp_addr,
                                    input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
        mem_ready = 1'b1;
        exp_q.push_back('{rdata: 32'h0, err: 1'b0});
        drive_req(1'b1, f3, a, wd);
        @(negedge clk);
        tests++;
        if ({mem_valid, mem_we, mem_wstrb, mem_addr, mem_wdata, req_ready} !==
            {1'b1, 1'b1, exp_strb, exp_addr, exp_wdata, 1'b0}) begin
            fails++;
            $display("FAIL store_mem a=%h: got valid=%b we=%b strb=%b addr=%h wdata=%h ready=%b, required 1 1 %b %h %h 0",
                     a, mem_valid, mem_we, mem_wstrb, mem_addr, mem_wdata, req_ready,
                     exp_strb, exp_addr, exp_wdata);
        end
        @(negedge clk);
        tests++;
        if ({resp_valid, mem_valid} !== 2'b10) begin
            fails++;
            $display("FAIL store_resp_timing a=%h: got resp_valid=%b mem_valid=%b, required 1 0",
                     a, resp_valid, mem_valid);
        end
    endtask

    task automatic test_stores();
        test_store_cycle(3'b010, 32'h100, 32'hDEADBEEF, 32'h100, 4'b1111, 32'hDEADBEEF);
        test_store_cycle(3'b000, 32'h203, 32'h000000A5, 32'h200, 4'b1000, 32'hA5A5A5A5);
        test_store_cycle(3'b001, 32'h102, 32'h1234BEEF, 32'h100, 4'b1100, 32'hBEEFBEEF);
    endtask

    task automatic test_loads();
        logic [2:0]  f3s  [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b010, 3'b001};
        logic [31:0] adrs [7] = '{32'h102, 32'h102, 32'h102, 32'h100, 32'h101, 32'h100, 32'h100};
        logic [31:0] exps [7] = '{32'hFFFFFFF0, 32'h000000F0, 32'h000012F0, 32'h00003456,
                                  32'h00000034, 32'h12F03456, 32'h00003456};
        mem_ready = 1'b1;
        mem_rdata = 32'h12F03456;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back('{rdata: exps[i], err: 1'b0});
            drive_req(1'b0, f3s[i], adrs[i], 32'hFFFFFFFF);
            @(negedge clk);
            tests++;
            if ({mem_valid, mem_we, mem_wstrb, mem_addr} !== {1'b1, 1'b0, 4'h0, 32'h100}) begin
                fails++;
                $display("FAIL load_mem %0d: got valid=%b we=%b strb=%b addr=%h, required 1 0 0000 00000100",
                         i, mem_valid, mem_we, mem_wstrb, mem_addr);
            end
            @(negedge clk);
            tests++;
            if (resp_valid !== 1'b1) begin
                fails++;
                $display("FAIL load_resp_timing %0d: got resp_valid=%b, required 1", i, resp_valid);
            end
        end
    endtask

    task automatic test_errors();
        logic        sts  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [2:0]  f3s  [4] = '{3'b010, 3'b011, 3'b001, 3'b100};
        logic [31:0] adrs [4] = '{32'h101, 32'h100, 32'h103, 32'h100};
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{rdata: 32'h0, err: 1'b1});
            drive_req(sts[i], f3s[i], adrs[i], 32'h12345678);
            @(negedge clk);
            tests++;
            if ({resp_valid, resp_err, mem_valid} !== 3'b110) begin
                fails++;
                $display("FAIL err_path %0d: got resp_valid=%b resp_err=%b mem_valid=%b, required 1 1 0",
                         i, resp_valid, resp_err, mem_valid);
            end
            @(negedge clk);
            tests++;
            if ({mem_valid, req_ready} !== 2'b01) begin
                fails++;
                $display("FAIL err_after %0d: got mem_valid=%b req_ready=%b, required 0 1",
                         i, mem_valid, req_ready);
            end
        end
    endtask

    task automatic test_stall();
        mem_ready = 1'b0;
        mem_rdata = 32'hCAFEBABE;
        exp_q.push_back('{rdata: 32'hCAFEBABE, err: 1'b0});
        drive_req(1'b0, 3'b010, 32'h104, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if ({mem_valid, mem_addr, req_ready, resp_valid} !== {1'b1, 32'h104, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL stall_hold %0d: got valid=%b addr=%h ready=%b resp_valid=%b, required 1 00000104 0 0",
                         i, mem_valid, mem_addr, req_ready, resp_valid);
            end
        end
        @(posedge clk); #1;
        mem_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        tests++;
        if ({resp_valid, mem_valid} !== 2'b10) begin
            fails++;
            $display("FAIL stall_resp: got resp_valid=%b mem_valid=%b, required 1 0", resp_valid, mem_valid);
        end
        @(negedge clk);
        tests++;
        if ({resp_valid, resp_rdata} !== {1'b0, 32'hCAFEBABE}) begin
            fails++;
            $display("FAIL resp_hold: got resp_valid=%b rdata=%h, required 0 cafebabe", resp_valid, resp_rdata);
        end
    endtask

    task automatic test_reset_abort();
        mem_ready = 1'b0;
        exp_q.push_back('{rdata: 32'h0, err: 1'b0});
        drive_req(1'b1, 3'b010, 32'h108, 32'h55AA55AA);
        @(negedge clk);
        tests++;
        if (mem_valid !== 1'b1) begin
            fails++;
            $display("FAIL abort_pre: got mem_valid=%b, required 1", mem_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        exp_q.delete();
        tests++;
        if ({req_ready, mem_valid, mem_we, mem_wstrb, mem_wdata, mem_addr,
             resp_valid, resp_rdata, resp_err} !== {1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
             1'b0, 32'h0, 1'b0}) begin
            fails++;
            $display("FAIL abort_async: got ready=%b mvalid=%b we=%b strb=%h wdata=%h addr=%h rvalid=%b rdata=%h err=%b, required ready=1 rest 0",
                     req_ready, mem_valid, mem_we, mem_wstrb, mem_wdata, mem_addr,
                     resp_valid, resp_rdata, resp_err);
        end
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if ({resp_valid, mem_valid, req_ready} !== 3'b001) begin
                fails++;
                $display("FAIL abort_after %0d: got resp_valid=%b mem_valid=%b req_ready=%b, required 0 0 1",
                         i, resp_valid, mem_valid, req_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cnt;
        cnt = 0;
        mem_ready = 1'b1;
        mem_rdata = 32'h11223344;
        exp_q.push_back('{rdata: 32'h11223344, err: 1'b0});
        exp_q.push_back('{rdata: 32'h11223344, err: 1'b0});
        @(posedge clk); #1;
        req_valid    = 1'b1;
        req_is_store = 1'b0;
        req_funct3   = 3'b010;
        req_addr     = 32'h100;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i == 5) req_valid = 1'b0;
            @(negedge clk);
            if (resp_valid === 1'b1) cnt++;
        end
        tests++;
        if (cnt != 2 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL back_to_back: got %0d responses (%0d pending), required 2 (0 pending)",
                     cnt, exp_q.size());
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_funct3   = 3'b000;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        mem_ready    = 1'b0;
        mem_rdata    = 32'h0;

        test_reset();
        test_stores();
        test_loads();
        test_errors();
        test_stall();
        test_reset_abort();
        test_back_to_back();

        repeat (3) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending responses, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the RV32I core. Consumes the effective address computed by the ALU (base + offset via its ADD operation) together with the access size/sign from funct3. Performs byte, halfword and word loads and stores over a valid/ready data-memory port, then returns sign- or zero-extended load data to writeback. Misaligned or undefined accesses are flagged without touching memory.

## Interface
- ADDR_WIDTH, 32: width of `req_addr` and `mem_addr`.
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  execute stage presents an access.
- req_ready  out  1  LSU can accept a request.
- req_is_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (size/signedness).
- req_addr  in  ADDR_WIDTH  effective address from ALU result.
- req_wdata  in  32  store data (rs2).
- mem_valid  out  1  memory request valid.
- mem_ready  in  1  memory accepts/completes request this cycle.
- mem_addr  out  ADDR_WIDTH  word-aligned address (`req_addr` with [1:0] forced to 0).
- mem_we  out  1  write enable.
- mem_wstrb  out  4  byte-lane strobes.
- mem_wdata  out  32  lane-aligned store data.
- mem_rdata  in  32  read data, valid in the cycle `mem_ready`=1 for a load.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data (0 for stores and errors).
- resp_err  out  1  misaligned or undefined funct3; qualified by `resp_valid`.

## Operation
- Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW. Any other funct3 is undefined and sets `err`.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0; sets `err`.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: `req_ready`=1. On `req_valid`, latch is_store, funct3, addr, wdata, and computed `err`. Go to RESP if `err`, otherwise to ACCESS.
  - ACCESS: `mem_valid`=1; every `mem_*` output is held stable from latched values. On `mem_ready`, capture extended load data and go to RESP. Otherwise stay in ACCESS indefinitely.
  - RESP: `resp_valid`=1 for exactly one cycle, then go to IDLE.
- Store lanes, with off = addr[1:0]:
  - SB: wstrb = 0001<<off; wdata = {4{b}}.
  - SH: wstrb = 0011<<off; wdata = {2{h}}.
  - SW: wstrb = 1111.
- Loads drive `mem_wstrb`=0 and `mem_we`=0.
- Load extraction selects the byte/halfword from `mem_rdata` at offset off. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.

## Timing
- Reset values: state = IDLE, `req_ready`=1. The following are all 0: `mem_valid`, `mem_we`, `mem_wstrb`, `mem_wdata`, `mem_addr`, `resp_valid`, `resp_rdata`, `resp_err`.
- Request accepted at edge N (IDLE, `req_valid`=1):
  - `mem_valid` rises in cycle N+1.
  - With `mem_ready` in cycle N+1+k, `resp_valid` occurs in cycle N+2+k. Minimum latency is 2 cycles.
- Error path: `resp_valid`=1 with `resp_err`=1 in cycle N+1; `mem_valid` never asserts.
- `req_ready` is low in ACCESS and RESP, so no new request is accepted during a response cycle. Back-to-back throughput is one access per 3 cycles at minimum.
- `mem_ready` outside ACCESS is ignored.
- `resp_rdata`/`resp_err` are registered and remain stable until the next response.
- Reset is asynchronous and abortive: assertion mid-ACCESS drops `mem_valid` immediately, and no response is produced.

## Structure
- Package `lsu_pkg`:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum (S_IDLE, S_ACCESS, S_RESP).
- Sub-module `lsu_align`, purely combinational:
  - Store path: (funct3, off, wdata) → (wstrb, lane data).
  - Load path: (funct3, off, rdata) → extended data.
  - Misalignment/undefined check → `err`.
- FSM and registers live in `load_store_unit`.

## Test plan
- SW addr 0x100, wdata 0xDEADBEEF, `mem_ready` tied 1 → `mem_valid` in N+1 with `mem_addr`=0x100, wstrb=1111, we=1; `resp_valid` in N+2, err=0.
- SB addr 0x203, wdata 0x000000A5 → `mem_addr`=0x200, wstrb=1000, wdata=0xA5A5A5A5.
- LB addr 0x102 and LBU addr 0x102, `mem_rdata`=0x12F03456 → resp_rdata 0xFFFFFFF0 and 0x000000F0. LH addr 0x102 → 0x000012F0.
- LW addr 0x101 → `resp_valid`+`resp_err` in N+1, `mem_valid` never high. Load with funct3=011 at addr 0x100 → err.
- LW with `mem_ready` held low 5 cycles → `mem_addr`/`mem_valid` stable throughout, `req_ready`=0; response in the cycle after `mem_ready`.
- Assert `rst_n` low mid-ACCESS → `mem_valid` drops asynchronously, all outputs at reset values, no `resp_valid` after release.
